// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: h/v counters, registered sync/blank/strobes,
// frame counter and a ce-qualified delayed copy of sync/de for downstream pipelines.
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CW       = 11,
  parameter int   FW       = 8,
  parameter int   DLY      = 2
) (
  input  logic          clk_p,
  input  logic          rst,
  input  logic          ce,
  input  logic          restart,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          sol,
  output logic          sof,
  output logic [FW-1:0] frame_cnt,
  output logic          hsync_d,
  output logic          vsync_d,
  output logic          de_d
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] H_SS   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SE   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] V_SS   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SE   = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0] h;
  logic [CW-1:0] v;
  logic          h_last;
  logic          v_last;

  assign h_last = (h == H_LAST);
  assign v_last = (v == V_LAST);

  // restart wins over the frame wrap, so a restart on the last pixel does not count a frame
  always_ff @(posedge clk_p or negedge rst) begin
    if (!rst) begin
      h         <= '0;
      v         <= '0;
      frame_cnt <= '0;
    end else if (ce) begin
      if (restart) begin
        h <= '0;
        v <= '0;
      end else if (h_last) begin
        h <= '0;
        if (v_last) begin
          v         <= '0;
          frame_cnt <= frame_cnt + 1'b1;
        end else begin
          v <= v + 1'b1;
        end
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  logic          de_n;
  logic          hs_n;
  logic          vs_n;
  logic [CW-1:0] x_n;
  logic [CW-1:0] y_n;

  always_comb begin
    de_n = (h < H_ACT) && (v < V_ACT);
    hs_n = ((h >= H_SS) && (h < H_SE)) ? HS_POL : ~HS_POL;
    vs_n = ((v >= V_SS) && (v < V_SE)) ? VS_POL : ~VS_POL;
    x_n  = de_n ? h : '0;
    y_n  = de_n ? v : '0;
  end

  always_ff @(posedge clk_p or negedge rst) begin
    if (!rst) begin
      hsync <= ~HS_POL;
      vsync <= ~VS_POL;
      de    <= 1'b0;
      x     <= '0;
      y     <= '0;
      sol   <= 1'b0;
      sof   <= 1'b0;
    end else if (ce) begin
      hsync <= hs_n;
      vsync <= vs_n;
      de    <= de_n;
      x     <= x_n;
      y     <= y_n;
      sol   <= (h == '0);
      sof   <= (h == '0) && (v == '0);
    end
  end

  generate
    if (DLY == 0) begin : g_no_dly
      assign hsync_d = hsync;
      assign vsync_d = vsync;
      assign de_d    = de;
    end else begin : g_dly
      // each stage holds {hsync, vsync, de}; stage 0 takes the registered outputs
      logic [2:0] stage [DLY];

      always_ff @(posedge clk_p or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < DLY; i++) stage[i] <= {~HS_POL, ~VS_POL, 1'b0};
        end else if (ce) begin
          stage[0] <= {hsync, vsync, de};
          for (int i = 1; i < DLY; i++) stage[i] <= stage[i-1];
        end
      end

      assign {hsync_d, vsync_d, de_d} = stage[DLY-1];
    end
  endgenerate

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA/raster timing generator; successor to the fixed 640x480 generator.
- Horizontal and vertical geometry, sync polarity and counter widths are parameters.
- Adds a pixel-clock enable, a frame-aligned soft restart, line/frame strobes, a frame counter, and a DLY-stage aligned copy of the sync/blank outputs for downstream pixel pipelines.
- Sits between the pixel clock domain and the video output / framebuffer read logic.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level (0 = active-low)
- CW, 11, width of counters and x/y outputs; must hold H_TOTAL-1 and V_TOTAL-1
- FW, 8, frame counter width
- DLY, 2, extra ce-qualified pipeline stages on the *_d outputs (0..15)

Ports:
- clk_p  in  1  pixel-domain clock
- rst  in  1  reset; asynchronous, active-low
- ce  in  1  pixel enable; counters and outputs advance only when 1
- restart  in  1  soft restart request
- hsync  out  1  horizontal sync, polarity HS_POL
- vsync  out  1  vertical sync, polarity VS_POL
- de  out  1  data enable (active video)
- x  out  CW  active-area column; 0 when de=0
- y  out  CW  active-area row; 0 when de=0
- sol  out  1  start-of-line strobe
- sof  out  1  start-of-frame strobe
- frame_cnt  out  FW  completed-frame count
- hsync_d  out  1  hsync delayed by DLY ce-cycles
- vsync_d  out  1  vsync delayed by DLY ce-cycles
- de_d  out  1  de delayed by DLY ce-cycles

Behaviour:
- Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 default); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 default).
- Region order, each axis: active, front porch, sync, back porch. Counter h/v = 0 is the first active pixel/line.
- Counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1) update only on ce=1 clocks.
  - h wraps to 0 after H_TOTAL-1.
  - v increments only on the h wrap and wraps to 0 after V_TOTAL-1.
- All outputs are registered and update only on ce=1 clocks; they hold when ce=0. One ce-cycle latency from counter value (h,v) to outputs:
  - de = (h<H_ACTIVE) & (v<V_ACTIVE)
  - x = de ? h : 0; y = de ? v : 0
  - hsync = HS_POL when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL
  - vsync = VS_POL when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (whole lines, independent of h), else ~VS_POL
  - sol = (h==0); sof = (h==0)&(v==0). Strobes last exactly one ce-cycle, i.e. they remain high across ce=0 gaps until the next ce clock.
- frame_cnt increments, modulo 2^FW, on the ce clock where h==H_TOTAL-1 and v==V_TOTAL-1.
- restart:
  - Sampled on ce clocks only.
  - Next counter state is (0,0), overriding normal increment and wrap.
  - Does not increment frame_cnt and does not clear it.
  - Output effect appears one ce-cycle later, as for a normal (0,0).
  - restart=1 held for consecutive ce clocks keeps the counters at (0,0), so sol/sof repeat every ce clock.
- Delay line:
  - hsync_d/vsync_d/de_d are the hsync/vsync/de register outputs passed through DLY ce-qualified stages.
  - DLY=0 makes them identical to hsync/vsync/de.
  - Stages shift only on ce=1.
- Reset (async assert, rst=0): h=v=0; frame_cnt=0; de=0; x=y=0; sol=sof=0; hsync=~HS_POL; vsync=~VS_POL; all delay stages loaded with de=0, hsync=~HS_POL, vsync=~VS_POL.
- Reset mid-frame returns immediately to the reset state. The first ce clock after release produces the outputs for (0,0): sol=sof=1, de=1.

Test Plan:
- Defaults, ce=1, run 2 frames:
  - de high 640 of every 800 clocks on lines 0..479.
  - hsync low for output cycles corresponding to h=656..751 (96 clocks).
  - vsync low on lines 490..491.
  - sof period = 420000 clocks; frame_cnt goes 0->1->2.
- Set H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=3, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=2, HS_POL=1:
  - hsync high exactly at h=10..12.
  - x counts 0..7 then 0.
  - sof every 16*8=128 clocks.
- ce toggling 1,0,0,1,... (1 in 3) with small geometry:
  - All outputs hold during ce=0.
  - sof period = 384 clocks; sol stays high for 3 clocks.
- restart at default h=300, v=100:
  - Next ce output has sol=sof=1, x=y=0.
  - frame_cnt unchanged.
  - restart coinciding with h=799, v=524: counters go to (0,0), frame_cnt not incremented.
- DLY=2 vs DLY=0 builds on the same stimulus: *_d edges lag hsync/vsync/de by exactly 2 ce-cycles, including across ce=0 gaps.
- Assert rst at h=123, v=45 mid-frame:
  - Outputs go to reset values asynchronously (hsync=vsync=1 for defaults).
  - After release, first ce clock gives de=1, sof=1, frame_cnt=0.
